multi_line_ram: RTL

Parametrised N-bank line buffer, the successor to the two-bank ping-pong line RAM in the algorithm pipeline.
- The writer fills one bank per video line while the NUM_BUF-1 most recently completed lines are read in parallel as vertical taps.
- Feeds 3x3/5x5 window filters after the sensor/ISP stream.
- Adds per-line flow-control accounting, overflow/underflow flags and a correct bank latch for the delayed write path.

---
 rtl/multi_line_ram_pkg.sv | 29 ++
 rtl/multi_line_ram_if.sv | 34 +++
 rtl/multi_line_ram_lb_bank_ram.sv | 23 ++
 rtl/multi_line_ram.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/multi_line_ram_pkg.sv
// Shared helpers for the multi-bank line buffer: sizing, parameter legality
// and the vertical-tap to bank mapping.
package line_buf_pkg;

  typedef enum logic [2:0] {
    LA_HOLD,
    LA_INC,
    LA_DEC,
    LA_OVF,
    LA_UNF
  } la_op_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit num_buf_ok(input int n);
    return (n >= 2) && (n <= 8);
  endfunction

  // Tap k (0 = newest completed line) lives in bank (wp-1-k) mod n.
  function automatic int tap_bank(input int wp, input int k, input int n);
    return (wp - 1 - k + 2 * n) % n;
  endfunction

endpackage

// File: rtl/multi_line_ram_if.sv
// Writer/consumer bundle of the line buffer; master = stream side, slave = buffer.
interface multi_line_ram_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 11,
  parameter int NUM_BUF = 3
);
  localparam int BW = line_buf_pkg::clog2(NUM_BUF);

  logic                          wr_en;
  logic [ADDR_W-1:0]             wr_addr;
  logic [DATA_W-1:0]             wr_data;
  logic                          wr_line_end;
  logic                          rd_en;
  logic [ADDR_W-1:0]             rd_addr;
  logic                          rd_line_done;
  logic [(NUM_BUF-1)*DATA_W-1:0] rd_data;
  logic                          rd_valid;
  logic [BW:0]                   lines_avail;
  logic [BW-1:0]                 wr_bank;
  logic                          overflow;
  logic                          underflow;
  logic                          rd_collision;

  modport master (
    output wr_en, wr_addr, wr_data, wr_line_end, rd_en, rd_addr, rd_line_done,
    input  rd_data, rd_valid, lines_avail, wr_bank, overflow, underflow, rd_collision
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_line_end, rd_en, rd_addr, rd_line_done,
    output rd_data, rd_valid, lines_avail, wr_bank, overflow, underflow, rd_collision
  );

endinterface

// File: rtl/multi_line_ram_lb_bank_ram.sv
// Single-port synchronous line bank: write has priority, 1-cycle registered read.
module lb_bank_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    else if (re)
      q <= mem[addr];
  end

endmodule

// File: rtl/multi_line_ram.sv
// N-bank line buffer: one bank is filled per line while the NUM_BUF-1 newest
// completed lines are read in parallel as vertical taps.
module multi_line_ram
  import line_buf_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 11,
  parameter int NUM_BUF = 3,
  parameter int WR_REG  = 1
) (
  input logic            clk,
  input logic            reset_n,
  multi_line_ram_if.slave bus
);

  localparam int          BW        = clog2(NUM_BUF);
  localparam int unsigned NT        = NUM_BUF - 1;
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BUF - 1);
  localparam logic [BW:0]   LA_MAX    = (BW + 1)'(NUM_BUF - 1);

  if (!num_buf_ok(NUM_BUF)) begin : g_bad_num_buf
    $error("multi_line_ram: NUM_BUF must be in 2..8");
  end

  logic [BW-1:0] wp;
  logic [BW:0]   la;
  logic          ovf_q, unf_q;
  la_op_e        la_op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wp <= '0;
    else if (bus.wr_line_end)
      wp <= (wp == LAST_BANK) ? '0 : wp + 1'b1;
  end

  // Effective RAM write port, either straight from the bus or one cycle late.
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [BW-1:0]     ram_wbank;

  if (WR_REG != 0) begin : g_wr_reg
    logic              d_en;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data;
    logic [BW-1:0]     d_bank;

    // Bank is latched with the pixel, so a pixel coincident with the line end
    // still lands in the line it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        d_en   <= 1'b0;
        d_addr <= '0;
        d_data <= '0;
        d_bank <= '0;
      end else begin
        d_en   <= bus.wr_en;
        d_addr <= bus.wr_addr;
        d_data <= bus.wr_data;
        d_bank <= wp;
      end
    end

    assign ram_we    = d_en;
    assign ram_waddr = d_addr;
    assign ram_wdata = d_data;
    assign ram_wbank = d_bank;
  end else begin : g_wr_direct
    assign ram_we    = bus.wr_en;
    assign ram_waddr = bus.wr_addr;
    assign ram_wdata = bus.wr_data;
    assign ram_wbank = wp;
  end

  logic [DATA_W-1:0]  bank_q [NUM_BUF];
  logic [NUM_BUF-1:0] bank_wsel;

  for (genvar b = 0; b < NUM_BUF; b++) begin : g_bank
    assign bank_wsel[b] = ram_we && (ram_wbank == BW'(b));

    lb_bank_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk   (clk),
      .we    (bank_wsel[b]),
      .re    (bus.rd_en & ~bank_wsel[b]),
      .addr  (bank_wsel[b] ? ram_waddr : bus.rd_addr),
      .wdata (ram_wdata),
      .q     (bank_q[b])
    );
  end

  logic [NT-1:0][BW-1:0]     tap_sel, tap_sel_r;
  logic [NT-1:0]             tap_coll, tap_coll_r;
  logic [NT-1:0][DATA_W-1:0] tap_hold, tap_out;
  logic                      rd_valid_r;

  always_comb begin
    tap_sel  = '0;
    tap_coll = '0;
    for (int unsigned k = 0; k < NT; k++) begin
      tap_sel[k]  = BW'(tap_bank(int'(wp), int'(k), NUM_BUF));
      tap_coll[k] = bank_wsel[tap_sel[k]];
    end
  end

  // Mapping and collision are frozen at rd_en so a following line end cannot remap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_r <= 1'b0;
      tap_sel_r  <= '0;
      tap_coll_r <= '0;
      tap_hold   <= '0;
    end else begin
      rd_valid_r <= bus.rd_en;
      tap_hold   <= tap_out;
      if (bus.rd_en) begin
        tap_sel_r  <= tap_sel;
        tap_coll_r <= tap_coll;
      end
    end
  end

  always_comb begin
    tap_out = tap_hold;
    if (rd_valid_r)
      for (int unsigned k = 0; k < NT; k++)
        if (!tap_coll_r[k]) tap_out[k] = bank_q[tap_sel_r[k]];
  end

  always_comb begin
    la_op = LA_HOLD;
    case ({bus.wr_line_end, bus.rd_line_done})
      2'b10:   la_op = (la == LA_MAX) ? LA_OVF : LA_INC;
      2'b01:   la_op = (la == '0)     ? LA_UNF : LA_DEC;
      default: la_op = LA_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      la    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      case (la_op)
        LA_INC:  la    <= la + 1'b1;
        LA_DEC:  la    <= la - 1'b1;
        LA_OVF:  ovf_q <= 1'b1;
        LA_UNF:  unf_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.rd_data      = tap_out;
  assign bus.rd_valid     = rd_valid_r;
  assign bus.rd_collision = rd_valid_r & (|tap_coll_r);
  assign bus.lines_avail  = la;
  assign bus.wr_bank      = wp;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule
